prdecoder4: RTL and testbench
=============================

PRDECODER4 -- requirements
Module: prdecoder4

Interface
REQ-001 The block SHALL have parameter HOLD, default 4, giving the number of cycles each decoded one-hot word is held (legal range 1..255).
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of input FIFO entries (power of two, 2..16).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port code, input, 2 bits: the priority code to decode (0..3).
REQ-006 The block SHALL have port code_valid, input, 1 bit: the code is offered this cycle.
REQ-007 The block SHALL have port code_ready, output, 1 bit: the FIFO can accept a code this cycle.
REQ-008 The block SHALL have port onehot, output, 4 bits: the decoded line, bit[code]=1.
REQ-009 The block SHALL have port out_valid, output, 1 bit: onehot is being driven (HOLD state).
REQ-010 The block SHALL have port busy, output, 1 bit: the FIFO is non-empty or the FSM is not IDLE.

Function
REQ-011 A code SHALL be accepted when code_valid and code_ready are both 1 at a rising edge.
REQ-012 code_ready SHALL equal !full, computed from registered FIFO state; a pop in the same cycle SHALL NOT raise code_ready.
REQ-013 The FIFO SHALL preserve acceptance order; read and write pointers SHALL wrap modulo DEPTH, with an occupancy counter 0..DEPTH.
REQ-014 The FSM SHALL have exactly three states: IDLE, HOLD and GAP.
REQ-015 In IDLE with the FIFO non-empty, the FSM SHALL pop one entry, register onehot = 1<<code, load the counter with HOLD-1, and go to HOLD.
REQ-016 In HOLD, out_valid SHALL be 1 and onehot stable; the counter SHALL decrement each cycle, and the FSM SHALL go to GAP in the cycle the counter equals 0.
REQ-017 In GAP, onehot SHALL be 0000 and out_valid 0 for exactly one cycle, after which the FSM SHALL return to IDLE.
REQ-018 Latency SHALL be: code accepted at edge E, onehot visible after edge E+2 when the FSM is IDLE and the FIFO is empty.
REQ-019 Back-to-back words SHALL repeat with period HOLD+2 cycles (HOLD + GAP + IDLE).
REQ-020 A push and a pop in the same cycle SHALL leave occupancy unchanged.
REQ-021 Outside HOLD, onehot SHALL be exactly 0000.

Reset
REQ-022 While rst_n=0 at an edge, the FSM SHALL go to IDLE, pointers, occupancy and counter SHALL clear, and onehot=0000, out_valid=0, busy=0, code_ready=1.
REQ-023 Reset asserted mid-HOLD SHALL discard the current word and all FIFO contents; no partial word SHALL resume.

Configuration
REQ-024 When macro PRDECODER4_STATS_EN is defined, the block SHALL add output dec_count, 8 bits, reset 0, incremented on each IDLE->HOLD transition and saturating at 255.
REQ-025 When PRDECODER4_STATS_EN is undefined, dec_count and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-026 Package prdecoder4_pkg SHALL hold the FSM state enum (IDLE, HOLD, GAP), the code_t (2-bit) and onehot_t (4-bit) typedefs, and the decode function code -> onehot.
REQ-027 The FIFO SHALL be a separate sub-module, prdecoder4_fifo, parameterized by DEPTH and width 2.

Verification
REQ-028 Reset then push code=2 at edge 1 -> onehot=0100 and out_valid=1 after edge 3 for 4 cycles, then 0000 for 1 cycle, busy falls after the GAP.
REQ-029 Push codes 3,0,1,2 back-to-back -> onehot sequence 1000,0001,0010,0100, each held 4 cycles with a 1-cycle 0000 gap, in order.
REQ-030 Push 6 codes with code_valid held high (DEPTH=4) -> code_ready=0 once occupancy reaches 4; no code lost or duplicated.
REQ-031 HOLD=1, push 1,1 -> 0010 for 1 cycle, 0000 for 1 cycle, period 3 cycles.
REQ-032 rst_n=0 for one edge during the second HOLD cycle with 2 words queued -> onehot=0000, code_ready=1, busy=0, and no further output.
REQ-033 With PRDECODER4_STATS_EN, 300 words -> dec_count=255; without the macro the same stimulus passes REQ-029 checks.

Source files
------------

// File: rtl/prdecoder4_pkg.sv
// ============================================================================
// Module      : prdecoder4_pkg
// Description : Shared types, FSM state encoding and the code -> one-hot
//               decode helper for the prdecoder4 block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prdecoder4_pkg;

  localparam int CODE_W   = 2;
  localparam int ONEHOT_W = 4;
  localparam int CNT_W    = 8;

  typedef logic [CODE_W-1:0]   code_t;
  typedef logic [ONEHOT_W-1:0] onehot_t;

  // IDLE / HOLD / GAP; prefixed so they never collide with the HOLD parameter
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  function automatic onehot_t decode(input code_t c);
    return onehot_t'(4'b0001 << c);
  endfunction

endpackage : prdecoder4_pkg

`default_nettype wire

// File: rtl/prdecoder4_fifo.sv
// ============================================================================
// Module      : prdecoder4_fifo
// Description : Small synchronous FIFO with occupancy counter. Push is
//               ignored when full, pop is ignored when empty. Read data is
//               the head entry (combinational from storage).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prdecoder4_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (count_q == OCC_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign dout_o  = mem_q[rptr_q];

  // Next pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (w_push) wptr_d = wptr_q + PTR_W'(1);
    if (w_pop)  rptr_d = rptr_q + PTR_W'(1);
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage write; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wptr_q] <= din_i;
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule : prdecoder4_fifo

`default_nettype wire

// File: rtl/prdecoder4.sv
// ============================================================================
// Module      : prdecoder4
// Description : Queued 2-to-4 priority decoder. Accepted codes are buffered
//               in a FIFO and each is presented as a one-hot word for HOLD
//               cycles followed by a one-cycle all-zero gap.
//               Optional build macro PRDECODER4_STATS_EN adds a saturating
//               8-bit dec_count output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prdecoder4
  import prdecoder4_pkg::*;
#(
  parameter int HOLD  = 4,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] code,
  input  logic       code_valid,
  output logic       code_ready,
  output logic [3:0] onehot,
  output logic       out_valid,
  output logic       busy
`ifdef PRDECODER4_STATS_EN
  ,
  output logic [7:0] dec_count
`endif
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  onehot_t          onehot_q, onehot_d;
  logic             settle_q;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  code_t            w_head;

  prdecoder4_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CODE_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (code_valid),
    .din_i   (code),
    .pop_i   (w_pop),
    .dout_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign code_ready = !w_full;
  assign onehot     = onehot_q;
  assign out_valid  = (state_q == ST_HOLD);
  assign busy       = !w_empty || (state_q != ST_IDLE);

  // Next-state logic: an entry may only be popped once the FIFO has been
  // non-empty for a full cycle, which yields the two-edge accept-to-output
  // latency while leaving back-to-back words at HOLD+2 cycles.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    onehot_d = onehot_q;
    w_pop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!w_empty && settle_q) begin
          w_pop    = 1'b1;
          onehot_d = decode(w_head);
          cnt_d    = CNT_W'(HOLD - 1);
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          onehot_d = '0;
          state_d  = ST_GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        onehot_d = '0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State, hold counter, output word and FIFO-settled flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      onehot_q <= '0;
      settle_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      onehot_q <= onehot_d;
      settle_q <= !w_empty;
    end
  end

`ifdef PRDECODER4_STATS_EN
  logic [7:0] dec_count_q;

  // Count IDLE->HOLD transitions, saturating at 255
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dec_count_q <= '0;
    end else if (w_pop && (dec_count_q != 8'hFF)) begin
      dec_count_q <= dec_count_q + 8'd1;
    end
  end

  assign dec_count = dec_count_q;
`endif

endmodule : prdecoder4

`default_nettype wire

// File: tb/tb_prdecoder4.sv
// ============================================================================
// Module      : tb_prdecoder4
// Description : Self-checking bench for prdecoder4 (HOLD=4 main instance,
//               HOLD=1 secondary instance). Build with PRDECODER4_STATS_EN
//               defined to also check dec_count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prdecoder4;

  localparam int HOLD  = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] code;
  logic       code_valid;
  logic       code_ready;
  logic [3:0] onehot;
  logic       out_valid;
  logic       busy;
  logic [1:0] code1;
  logic       valid1;
  logic       code_ready1;
  logic [3:0] onehot1;
  logic       out_valid1;
  logic       busy1;
`ifdef PRDECODER4_STATS_EN
  logic [7:0] dec_count;
  logic [7:0] dec_count1;
`endif

  always #5 clk = ~clk;

  prdecoder4 #(.HOLD(HOLD), .DEPTH(DEPTH)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .onehot     (onehot),
    .out_valid  (out_valid),
    .busy       (busy)
`ifdef PRDECODER4_STATS_EN
    ,
    .dec_count  (dec_count)
`endif
  );

  prdecoder4 #(.HOLD(1), .DEPTH(DEPTH)) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .code       (code1),
    .code_valid (valid1),
    .code_ready (code_ready1),
    .onehot     (onehot1),
    .out_valid  (out_valid1),
    .busy       (busy1)
`ifdef PRDECODER4_STATS_EN
    ,
    .dec_count  (dec_count1)
`endif
  );

  // Reference model: every accepted word gets a start edge
  //   start = max(accept_edge + 2, previous_start + HOLD + 2)
  // and is shown for edges start .. start+HOLD-1, gap at start+HOLD.
  int q_code  [$];
  int q_start [$];
  int prev_start;
  bit have_prev;
  int t;
  int started;
  int n_acc;
  int n_cmp;
  int n_fail;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  // One clock of main-instance stimulus with model update and checks
  task automatic tick(input logic v, input logic [1:0] c, input logic rn);
    int       pend;
    int       st;
    logic     acc;
    logic [3:0] eo;
    logic     ev;
    code       = c;
    code_valid = v;
    rst_n      = rn;
    pend = 0;
    foreach (q_start[i]) if (q_start[i] >= t + 1) pend++;
    chk("code_ready", 8'(code_ready), 8'(pend < DEPTH));
    acc = rn && v && (pend < DEPTH);
    @(posedge clk);
    t++;
    if (!rn) begin
      q_code.delete();
      q_start.delete();
      have_prev = 1'b0;
      started   = 0;
    end else if (acc) begin
      st = t + 2;
      if (have_prev && (prev_start + HOLD + 2 > st)) st = prev_start + HOLD + 2;
      q_code.push_back(int'(c));
      q_start.push_back(st);
      prev_start = st;
      have_prev  = 1'b1;
      n_acc++;
    end
    foreach (q_start[i]) if (q_start[i] == t) started++;
    while (q_start.size() > 0 && q_start[0] + HOLD < t) begin
      void'(q_start.pop_front());
      void'(q_code.pop_front());
    end
    #1;
    eo = 4'b0000;
    ev = 1'b0;
    foreach (q_start[i]) begin
      if (q_start[i] <= t && t <= q_start[i] + HOLD - 1) begin
        eo = 4'(1 << q_code[i]);
        ev = 1'b1;
      end
    end
    chk("onehot", 8'(onehot), 8'(eo));
    chk("out_valid", 8'(out_valid), 8'(ev));
    chk("busy", 8'(busy), 8'(q_start.size() != 0));
`ifdef PRDECODER4_STATS_EN
    chk("dec_count", dec_count, 8'((started > 255) ? 255 : started));
`endif
  endtask

  initial begin
    int         base;
    int         guard;
    logic [3:0] h1_exp [6];
    h1_exp = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
    rst_n = 1'b0; code = '0; code_valid = 1'b0; code1 = '0; valid1 = 1'b0;
    t = 0; started = 0; n_acc = 0; n_cmp = 0; n_fail = 0;
    have_prev = 1'b0; prev_start = 0;

    // Reset: one raw edge, then modelled reset edges check the idle state
    @(posedge clk);
    #1;
    tick(1'b0, 2'd0, 1'b0);
    tick(1'b1, 2'd3, 1'b0);

    // Single word code=2: latency, hold, gap, busy fall
    tick(1'b1, 2'd2, 1'b1);
    repeat (10) tick(1'b0, 2'd0, 1'b1);

    // Back-to-back 3,0,1,2
    tick(1'b1, 2'd3, 1'b1);
    tick(1'b1, 2'd0, 1'b1);
    tick(1'b1, 2'd1, 1'b1);
    tick(1'b1, 2'd2, 1'b1);
    repeat (30) tick(1'b0, 2'd0, 1'b1);

    // valid held high for six random codes: FIFO fills, ready drops
    base = n_acc;
    guard = 0;
    while ((n_acc - base < 6) && (guard < 60)) begin
      tick(1'b1, 2'($urandom_range(0, 3)), 1'b1);
      guard++;
    end
    chk("fill_accepts", 8'(n_acc - base), 8'd6);
    repeat (45) tick(1'b0, 2'd0, 1'b1);

    // Reset during the second HOLD cycle with two words queued
    tick(1'b1, 2'd1, 1'b1);
    tick(1'b1, 2'd2, 1'b1);
    tick(1'b1, 2'd3, 1'b1);
    tick(1'b0, 2'd0, 1'b1);
    chk("pre_reset_onehot", 8'(onehot), 8'h02);
    tick(1'b0, 2'd0, 1'b0);
    chk("post_reset_onehot", 8'(onehot), 8'h00);
    chk("post_reset_busy", 8'(busy), 8'h00);
    repeat (20) tick(1'b0, 2'd0, 1'b1);

    // Randomized traffic: 300 accepted words
    base = n_acc;
    guard = 0;
    while ((n_acc - base < 300) && (guard < 6000)) begin
      tick(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0, 2'($urandom_range(0, 3)), 1'b1);
      guard++;
    end
    chk("random_accept_bound", 8'(n_acc - base >= 300), 8'd1);
    guard = 0;
    while ((q_start.size() != 0) && (guard < 3000)) begin
      tick(1'b0, 2'd0, 1'b1);
      guard++;
    end
    chk("drain_busy", 8'(busy), 8'h00);

    // HOLD=1 instance: push 1,1 -> 0010, 0000, 0000, 0010, ...
    code1  = 2'd1;
    valid1 = 1'b1;
    chk("h1_ready", 8'(code_ready1), 8'd1);
    tick(1'b0, 2'd0, 1'b1);
    tick(1'b0, 2'd0, 1'b1);
    valid1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 2'd0, 1'b1);
      chk("h1_onehot", 8'(onehot1), 8'(h1_exp[i]));
      chk("h1_out_valid", 8'(out_valid1), 8'(h1_exp[i] != 4'b0000));
    end
    chk("h1_busy_end", 8'(busy1), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_prdecoder4

`default_nettype wire
